// File: rtl/freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : freq_meter                                                 |
// | Description : Gated-window frequency meter. Synchronises sig_in, counts  |
// |               its rising edges over GATE_CYCLES clocks and publishes the |
// |               saturated count with a one-cycle valid strobe.             |
// |               Optional macro FREQ_METER_PERIOD_EN adds edge-to-edge      |
// |               period measurement (period_cnt / period_valid).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_valid
);

  localparam int               GCW       = $clog2(GATE_CYCLES);
  localparam logic [GCW-1:0]   GATE_LAST = GCW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [1:0]       arm_cnt;
  logic [GCW-1:0]   gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;
  logic             sync1, sync2, sync3;
  logic             edge_p;
  logic             gate_last;
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Two-flop synchroniser plus a history flop for rising-edge detection
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_p    = sync2 & ~sync3;
  assign gate_last = (state == ST_GATE) && (gate_cnt == GATE_LAST);
  assign cnt_full  = (edge_cnt == CNT_MAX);
  // Count including this cycle's edge, held at all-ones once full
  assign cnt_next  = (edge_p && !cnt_full) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign ovf_next  = ovf | (edge_p & cnt_full);

  // Next-state decode; a dropped enable aborts ARM or a non-final GATE cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (enable) state_nx = ST_ARM;
      ST_ARM: begin
        if (!enable)              state_nx = ST_IDLE;
        else if (arm_cnt == 2'd2) state_nx = ST_GATE;
      end
      ST_GATE: begin
        if (gate_last)    state_nx = enable ? ST_GATE : ST_IDLE;
        else if (!enable) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, window counters and published results
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      arm_cnt    <= 2'd0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      freq_cnt   <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != ST_IDLE);
      freq_valid <= 1'b0;
      case (state)
        ST_ARM: begin
          // Edges seen while the synchroniser fills are ignored
          arm_cnt  <= arm_cnt + 2'd1;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
        end
        ST_GATE: begin
          if (gate_last) begin
            freq_cnt   <= cnt_next;
            freq_ovf   <= ovf_next;
            freq_valid <= 1'b1;
            // Back-to-back windows restart here with no dead cycle
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GCW'(1);
            edge_cnt <= cnt_next;
            ovf      <= ovf_next;
          end
        end
        default: begin
          arm_cnt  <= 2'd0;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt;
  logic             per_armed;

  // Edge-to-edge period; the first edge after ARM only restarts the count
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt      <= '0;
      per_armed    <= 1'b0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (state == ST_GATE && edge_p) begin
        per_cnt   <= CNT_W'(1);
        per_armed <= 1'b1;
        if (per_armed) begin
          period_cnt   <= per_cnt;
          period_valid <= 1'b1;
        end
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
        if (state != ST_GATE)   per_armed <= 1'b0;
      end
    end
  end
`else
  assign period_cnt   = '0;
  assign period_valid = 1'b0;
`endif

endmodule
`default_nettype wire
